// File: rtl/tensor_fadd_arbiter.sv
// Round-robin front end sharing one pipelined FP32 vector adder among NUM_REQS
// requesters: registered issue stage, credit-bounded in-flight ops, tag-routed result slots.
module tensor_fadd_arbiter #(
  parameter int NUM_REQS        = 4,
  parameter int DATAW           = 128,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAGW            = $clog2(NUM_REQS)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [NUM_REQS-1:0]                 req_valid_i,
  output logic [NUM_REQS-1:0]                 req_ready_o,
  input  logic [NUM_REQS-1:0][2*DATAW-1:0]    req_operands_i,
  output logic [NUM_REQS-1:0]                 rsp_valid_o,
  input  logic [NUM_REQS-1:0]                 rsp_ready_i,
  output logic [NUM_REQS-1:0][DATAW-1:0]      rsp_result_o,
  output logic [NUM_REQS-1:0][4:0]            rsp_fflags_o,
  output logic                                fpu_valid_in_o,
  input  logic                                fpu_ready_in_i,
  output logic [2*DATAW-1:0]                  fpu_operands_o,
  output logic [TAGW-1:0]                     fpu_tag_in_o,
  input  logic                                fpu_valid_out_i,
  output logic                                fpu_ready_out_o,
  input  logic [DATAW-1:0]                    fpu_result_i,
  input  logic [4:0]                          fpu_status_i,
  input  logic [TAGW-1:0]                     fpu_tag_i,
  output logic                                fpu_flush_o,
  output logic                                busy_o
);

  localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

  logic [TAGW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 issue_valid_q, issue_valid_d;
  logic [2*DATAW-1:0]   issue_ops_q, issue_ops_d;
  logic [TAGW-1:0]      issue_tag_q, issue_tag_d;
  logic [CNTW-1:0]      credits_q, credits_d;

  logic [NUM_REQS-1:0]  slot_full;
  logic [NUM_REQS-1:0]  accept_vec;
  logic [TAGW-1:0]      grant_idx;
  logic                 can_issue;
  logic                 accept;
  logic                 issue_fire;
  logic                 ret_fire;
  logic                 ret_dec;

  // Cyclic distance of a requester from the round-robin pointer; smaller wins.
  function automatic int rr_dist(int idx, logic [TAGW-1:0] ptr);
    return (idx + NUM_REQS - int'(ptr)) % NUM_REQS;
  endfunction

  assign can_issue = (~issue_valid_q | fpu_ready_in_i)
                   & (credits_q < CNTW'(MAX_OUTSTANDING))
                   & ~reset_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_req
      logic             blocked;
      logic             full_q, full_d;
      logic [DATAW-1:0] result_q, result_d;
      logic [4:0]       fflags_q, fflags_d;
      logic             load;

      // Ready only looks at requesters ahead of this one, never at its own valid.
      always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < NUM_REQS; j++) begin
          if (req_valid_i[j] && (rr_dist(j, rr_ptr_q) < rr_dist(gi, rr_ptr_q))) begin
            blocked = 1'b1;
          end
        end
      end

      assign req_ready_o[gi] = can_issue & ~blocked;

      assign load = ret_fire & (fpu_tag_i == TAGW'(gi));

      always_comb begin
        full_d   = full_q;
        result_d = result_q;
        fflags_d = fflags_q;
        if (load) begin
          full_d   = 1'b1;
          result_d = fpu_result_i;
          fflags_d = fpu_status_i;
        end else if (full_q && rsp_ready_i[gi]) begin
          full_d = 1'b0;
        end
      end

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          full_q   <= 1'b0;
          result_q <= '0;
          fflags_q <= '0;
        end else begin
          full_q   <= full_d;
          result_q <= result_d;
          fflags_q <= fflags_d;
        end
      end

      assign slot_full[gi]    = full_q;
      assign rsp_valid_o[gi]  = full_q;
      assign rsp_result_o[gi] = result_q;
      assign rsp_fflags_o[gi] = fflags_q;
    end
  endgenerate

  assign accept_vec = req_valid_i & req_ready_o;
  assign accept     = |accept_vec;
  assign issue_fire = issue_valid_q & fpu_ready_in_i;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (accept_vec[i]) begin
        grant_idx = TAGW'(i);
      end
    end
  end

  // A full slot only accepts a new result if its requester drains it this cycle.
  assign fpu_ready_out_o = ~reset_i & (~slot_full[fpu_tag_i] | rsp_ready_i[fpu_tag_i]);
  assign ret_fire        = fpu_valid_out_i & fpu_ready_out_o;
  assign ret_dec         = ret_fire & (credits_q != '0);

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_ops_d   = issue_ops_q;
    issue_tag_d   = issue_tag_q;
    rr_ptr_d      = rr_ptr_q;
    if (accept) begin
      issue_valid_d = 1'b1;
      issue_ops_d   = req_operands_i[grant_idx];
      issue_tag_d   = grant_idx;
      rr_ptr_d      = (grant_idx == TAGW'(NUM_REQS - 1)) ? '0 : grant_idx + TAGW'(1);
    end else if (issue_fire) begin
      issue_valid_d = 1'b0;
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({accept, ret_dec})
      2'b10:   credits_d = credits_q + CNTW'(1);
      2'b01:   credits_d = credits_q - CNTW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_ops_q   <= '0;
      issue_tag_q   <= '0;
      credits_q     <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_ops_q   <= issue_ops_d;
      issue_tag_q   <= issue_tag_d;
      credits_q     <= credits_d;
    end
  end

  assign fpu_valid_in_o = issue_valid_q;
  assign fpu_operands_o = issue_ops_q;
  assign fpu_tag_in_o   = issue_tag_q;
  assign fpu_flush_o    = reset_i;
  assign busy_o         = (credits_q != '0) | (|slot_full);

endmodule
